// File: rtl/fractal_pkg.sv
// rtl/fractal_pkg.sv - shared line-reader state encoding and RAM read latency
package fractal_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } line_state_t;

    localparam int RAM_LATENCY = 2;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word fall-through FIFO with occupancy count and flush
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic                     valid,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible while count is non-zero.
    always_ff @(posedge clock) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

    always_comb begin
        valid     = (count_q != '0);
        head_data = valid ? mem_q[rd_ptr_q] : '0;
        count     = count_q;
    end

endmodule

// File: rtl/ram_line_reader.sv
// rtl/ram_line_reader.sv - streams one RAM line out with credit-limited reads; RAM_LINE_READER_ABORT_EN adds abort
module ram_line_reader
    import fractal_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [ADDR_W-1:0]        len_m1,
    output logic                     start_ready,
    output logic                     rd_en,
    output logic [ADDR_W-1:0]        rd_addr,
    input  logic signed [DATA_W-1:0] ram_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic signed [DATA_W-1:0] m_data,
    output logic                     m_last,
`ifdef RAM_LINE_READER_ABORT_EN
    input  logic                     abort,
`endif
    output logic                     busy
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;

    line_state_t            state_q, state_d;
    logic [ADDR_W-1:0]      rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0]      remain_q, remain_d;
    logic [RAM_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    logic [RAM_LATENCY-1:0] pipe_last_q, pipe_last_d;
    logic [CNT_W-1:0]       fifo_count;
    logic [OCC_W-1:0]       occupancy;
    logic                   kill, issue, issue_last, fifo_pop, head_last;

`ifdef RAM_LINE_READER_ABORT_EN
    assign kill = abort && (state_q != ST_IDLE);
`else
    assign kill = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start)                  state_d = ST_ISSUE;
            ST_ISSUE: if (issue_last)             state_d = ST_DRAIN;
            ST_DRAIN: if (fifo_pop && head_last)  state_d = ST_IDLE;
            default:                              state_d = ST_IDLE;
        endcase
        if (kill) state_d = ST_IDLE;
    end

    // Credit counts everything already requested but not yet popped; a pop
    // in this same cycle is deliberately not counted as freeing a slot.
    always_comb begin
        occupancy = OCC_W'(fifo_count);
        for (int i = 0; i < RAM_LATENCY; i++) begin
            occupancy = occupancy + OCC_W'(pipe_vld_q[i]);
        end
        start_ready = (state_q == ST_IDLE);
        busy        = !start_ready;
        issue       = (state_q == ST_ISSUE) && !kill && (occupancy < OCC_W'(FIFO_DEPTH));
        issue_last  = issue && (remain_q == '0);
        rd_en       = issue;
        rd_addr     = rd_addr_q;
    end

    always_comb begin
        rd_addr_d = rd_addr_q;
        remain_d  = remain_q;
        if (start_ready && start) begin
            rd_addr_d = base_addr;
            remain_d  = len_m1;
        end else if (issue) begin
            rd_addr_d = rd_addr_q + ADDR_W'(1);
            remain_d  = remain_q - ADDR_W'(1);
        end
        pipe_vld_d  = {pipe_vld_q[RAM_LATENCY-2:0], issue};
        pipe_last_d = {pipe_last_q[RAM_LATENCY-2:0], issue_last};
        if (kill) begin
            pipe_vld_d  = '0;
            pipe_last_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_addr_q   <= '0;
            remain_q    <= '0;
            pipe_vld_q  <= '0;
            pipe_last_q <= '0;
        end else begin
            rd_addr_q   <= rd_addr_d;
            remain_q    <= remain_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_last_q <= pipe_last_d;
        end
    end

    assign fifo_pop = m_valid && m_ready;

    sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (kill),
        .push      (pipe_vld_q[RAM_LATENCY-1]),
        .push_data ({pipe_last_q[RAM_LATENCY-1], ram_data}),
        .pop       (m_ready),
        .valid     (m_valid),
        .head_data ({head_last, m_data}),
        .count     (fifo_count)
    );

    assign m_last = head_last;

endmodule

// File: tb/tb_ram_line_reader.sv
// tb/tb_ram_line_reader.sv - self-checking bench for ram_line_reader with a queue-based line model
module tb_ram_line_reader;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int NWORDS = 1024;

    logic                     clock = 1'b0;
    logic                     reset_n, start, m_ready;
    logic [ADDR_W-1:0]        base_addr, len_m1;
    logic                     start_ready, rd_en, m_valid, m_last, busy;
    logic [ADDR_W-1:0]        rd_addr;
    logic signed [DATA_W-1:0] ram_data, ram_s1, m_data;
    logic signed [DATA_W-1:0] mem [NWORDS];
`ifdef RAM_LINE_READER_ABORT_EN
    logic                     abort;
`endif

    typedef struct {
        int data;
        bit last;
        int cyc;
    } word_t;

    word_t exp_q[$];
    word_t pop_log[$];
    int    exp_addr_q[$];
    int    addr_log[$];
    int    accept_log[$];

    bit model_busy = 1'b0;
    bit prev_stall = 1'b0;
    bit prev_last;
    int prev_data;
    int issued  = 0;
    int popped  = 0;
    int max_out = 0;
    int cyc     = 0;
    int n_pass  = 0;
    int n_total = 0;

    ram_line_reader #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .base_addr   (base_addr),
        .len_m1      (len_m1),
        .start_ready (start_ready),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .ram_data    (ram_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last),
`ifdef RAM_LINE_READER_ABORT_EN
        .abort       (abort),
`endif
        .busy        (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Two-cycle RAM: address sampled at one edge, data visible after the next.
    always @(posedge clock) begin
        ram_s1   <= mem[rd_addr];
        ram_data <= ram_s1;
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Line model: on acceptance the whole expected address/word sequence is queued.
    always @(negedge clock) begin
        bit    was_busy;
        word_t w;
        if (reset_n) begin
            was_busy = model_busy;
            check("busy", busy, model_busy);
            check("start_ready", start_ready, !model_busy);
`ifdef RAM_LINE_READER_ABORT_EN
            if (abort && was_busy) check("rd_en_during_abort", rd_en, 0);
`endif
            if (rd_en) begin
                check("read_expected", exp_addr_q.size() > 0, 1);
                if (exp_addr_q.size() > 0) check("rd_addr", rd_addr, exp_addr_q.pop_front());
                check("outstanding_below_depth", (issued - popped) < DEPTH, 1);
                addr_log.push_back(int'(rd_addr));
            end
            if (issued - popped + int'(rd_en) > max_out) max_out = issued - popped + int'(rd_en);
            if (prev_stall) begin
                check("stall_hold_valid", m_valid, 1);
                check("stall_hold_data", m_data, prev_data);
                check("stall_hold_last", m_last, prev_last);
            end
            if (start && !was_busy) begin
                model_busy = 1'b1;
                accept_log.push_back(cyc);
                for (int i = 0; i <= int'(len_m1); i++) begin
                    int a;
                    a = (int'(base_addr) + i) % NWORDS;
                    exp_addr_q.push_back(a);
                    w.data = int'(mem[a]);
                    w.last = (i == int'(len_m1));
                    w.cyc  = 0;
                    exp_q.push_back(w);
                end
            end
            if (m_valid) begin
                check("word_expected", exp_q.size() > 0, 1);
                if (m_ready && exp_q.size() > 0) begin
                    w = exp_q.pop_front();
                    check("m_data", m_data, w.data);
                    check("m_last", m_last, w.last);
                    w.data = int'(m_data);
                    w.last = m_last;
                    w.cyc  = cyc;
                    pop_log.push_back(w);
                    popped++;
                    if (w.last) model_busy = 1'b0;
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = int'(m_data);
            prev_last  = m_last;
            if (rd_en) issued++;
`ifdef RAM_LINE_READER_ABORT_EN
            if (abort && was_busy) begin
                exp_q.delete();
                exp_addr_q.delete();
                model_busy = 1'b0;
                popped     = issued;
                prev_stall = 1'b0;
            end
`endif
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_logs();
        pop_log.delete();
        addr_log.delete();
        accept_log.delete();
        max_out = 0;
    endtask

    task automatic wait_accept(input int n, input int budget, input string name);
        int k = 0;
        while (accept_log.size() < n && k < budget) begin tick(); k++; end
        check({name, "_accept_in_time"}, accept_log.size() >= n, 1);
    endtask

    task automatic wait_pops(input int n, input int budget, input string name);
        int k = 0;
        while (pop_log.size() < n && k < budget) begin tick(); k++; end
        check({name, "_pops_in_time"}, pop_log.size() >= n, 1);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k = 0;
        while (model_busy && k < budget) begin tick(); k++; end
        check({name, "_line_done_in_time"}, model_busy, 0);
    endtask

    task automatic run_line(input int base, input int len, input int budget, input string name);
        clear_logs();
        base_addr = ADDR_W'(base);
        len_m1    = ADDR_W'(len);
        start     = 1'b1;
        wait_accept(1, 8, name);
        start = 1'b0;
        wait_idle(budget, name);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_rd_en"}, rd_en, 0);
        check({name, "_rd_addr"}, rd_addr, 0);
        check({name, "_m_valid"}, m_valid, 0);
        check({name, "_m_data"}, m_data, 0);
        check({name, "_m_last"}, m_last, 0);
        check({name, "_busy"}, busy, 0);
        check({name, "_start_ready"}, start_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lasts;
        for (int i = 0; i < NWORDS; i++) mem[i] = DATA_W'(i - 128);
        reset_n   = 1'b0;
        start     = 1'b0;
        m_ready   = 1'b1;
        base_addr = '0;
        len_m1    = '0;
`ifdef RAM_LINE_READER_ABORT_EN
        abort     = 1'b0;
`endif
        tick();
        tick();
        check_reset_outputs("reset");
        reset_n = 1'b1;
        tick();

        // Line at 0 followed back-to-back by a wrapping line at 1020.
        clear_logs();
        base_addr = 10'd0;
        len_m1    = 10'd7;
        start     = 1'b1;
        wait_accept(1, 8, "line0");
        base_addr = 10'd1020;
        wait_accept(2, 40, "line1020");
        start = 1'b0;
        wait_idle(60, "line1020");
        check("two_lines_word_count", pop_log.size(), 16);
        check("first_valid_latency", pop_log[0].cyc - accept_log[0] - 1, 3);
        check("line0_span_cycles", pop_log[7].cyc - pop_log[0].cyc, 7);
        check("line0_word0", pop_log[0].data, -128);
        check("line0_word7", pop_log[7].data, -121);
        check("line0_last_on_8th", pop_log[7].last, 1);
        check("line0_no_early_last", pop_log[6].last, 0);
        check("back_to_back_accept", accept_log[1], pop_log[7].cyc + 1);
        check("wrap_addr_top", addr_log[11], 1023);
        check("wrap_addr_zero", addr_log[12], 0);
        check("line1020_word0", pop_log[8].data, 124);
        check("line1020_word4", pop_log[12].data, -128);
        check("line1020_word7", pop_log[15].data, -125);

        // Consumer stall of 10 cycles, with a start pulse that must be ignored.
        clear_logs();
        base_addr = 10'd100;
        len_m1    = 10'd15;
        start     = 1'b1;
        wait_accept(1, 8, "stall");
        start = 1'b0;
        wait_pops(4, 20, "stall");
        m_ready   = 1'b0;
        base_addr = 10'd500;
        start     = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        m_ready = 1'b1;
        wait_idle(80, "stall");
        check("stall_word_count", pop_log.size(), 16);
        check("stall_gap_cycles", pop_log[4].cyc - pop_log[3].cyc, 11);
        check("stall_word4", pop_log[4].data, -24);
        check("stall_max_outstanding", max_out, DEPTH);

        // Full-length line.
        run_line(0, 1023, 1200, "full");
        lasts = 0;
        foreach (pop_log[i]) if (pop_log[i].last) lasts++;
        check("full_word_count", pop_log.size(), 1024);
        check("full_single_last", lasts, 1);
        check("full_last_index", pop_log[1023].last, 1);
        check("full_word1023", pop_log[1023].data, 127);
        check("full_sustained_rate", pop_log[1023].cyc - pop_log[0].cyc, 1023);
        check("full_start_ready_after", start_ready, 1);

        // Asynchronous reset in the middle of a line.
        clear_logs();
        base_addr = 10'd50;
        len_m1    = 10'd31;
        start     = 1'b1;
        wait_accept(1, 8, "midreset");
        start = 1'b0;
        wait_pops(5, 20, "midreset");
        #2;
        reset_n = 1'b0;
        exp_q.delete();
        exp_addr_q.delete();
        model_busy = 1'b0;
        prev_stall = 1'b0;
        popped     = issued;
        #1;
        check_reset_outputs("midreset");
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        run_line(200, 5, 40, "after_reset");
        check("after_reset_word_count", pop_log.size(), 6);
        check("after_reset_word0", pop_log[0].data, 72);
        check("after_reset_word5", pop_log[5].data, 77);

`ifdef RAM_LINE_READER_ABORT_EN
        clear_logs();
        base_addr = 10'd300;
        len_m1    = 10'd15;
        start     = 1'b1;
        wait_accept(1, 8, "abort");
        start = 1'b0;
        wait_pops(3, 20, "abort");
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_m_valid_next", m_valid, 0);
        check("abort_busy_next", busy, 0);
        check("abort_start_ready_next", start_ready, 1);
        run_line(0, 3, 40, "after_abort");
        check("after_abort_word_count", pop_log.size(), 4);
        check("after_abort_word0", pop_log[0].data, -128);
        check("after_abort_last", pop_log[3].last, 1);
`endif

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
